uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It watches the receiver's busy line, captures each completed byte from the receiver's parallel data bus, and stores it in a small first-word-fall-through FIFO. The host logic drains the FIFO with a single-cycle read strobe. The block runs on the receiver's 16x oversampling clock, so it needs no clock-domain crossing.

---
 rtl/uart_rx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer placed directly behind the UART receiver. A small
// capture FSM watches the receiver busy line and generates one push per frame
// on the busy falling edge, sampling the receiver's parallel byte in that same
// cycle. Bytes are held in a first-word-fall-through FIFO that the host drains
// with a single-cycle read strobe. Everything runs on the receiver's 16x
// oversampling clock, so no clock-domain crossing is required.
//
// Parameters:
//   DEPTH     number of byte entries (power of two, 2..16)
//   AW        pointer width, log2(DEPTH)
//
// Ports:
//   ISCLK     in   16x oversampling clock shared with the receiver
//   IRST_N    in   asynchronous active-low reset
//   IRXDATA   in   [7:0] byte from the receiver, stable when IRX_BUSY falls
//   IRX_BUSY  in   receiver busy, start-bit detection to end of stop bit
//   IRD       in   pop strobe, one pop per cycle it is high
//   ICLR_OVR  in   clears the sticky overrun flag
//   ODATA     out  [7:0] head-of-FIFO byte, 8'h00 when empty
//   OVALID    out  FIFO not empty
//   OFULL     out  FIFO holds DEPTH bytes
//   OCOUNT    out  [AW:0] number of stored bytes
//   OOVERRUN  out  sticky flag, set when a byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          ISCLK,
    input  logic          IRST_N,
    input  logic [7:0]    IRXDATA,
    input  logic          IRX_BUSY,
    input  logic          IRD,
    input  logic          ICLR_OVR,
    output logic [7:0]    ODATA,
    output logic          OVALID,
    output logic          OFULL,
    output logic [AW:0]   OCOUNT,
    output logic          OOVERRUN
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } cap_state_e;

    localparam logic [AW-1:0] PTR_INC  = AW'(1);
    localparam logic [AW:0]   CNT_INC  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [AW:0]       count_q, count_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        mem_q [DEPTH];

    logic              push_s;
    logic              pop_s;
    logic              push_acc_s;
    logic              drop_s;

    // Capture FSM next state: one push per busy pulse, issued on the cycle busy is seen low
    always_comb begin
        state_d = state_q;
        push_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IRX_BUSY) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!IRX_BUSY) begin
                    push_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
                push_s  = 1'b0;
            end
        endcase
    end

    // Pop/push qualification; a pop frees the slot a simultaneous push lands in
    always_comb begin
        pop_s      = IRD && (count_q != CNT_ZERO);
        push_acc_s = push_s && ((count_q != CNT_FULL) || pop_s);
        drop_s     = push_s && !push_acc_s;
    end

    // Pointer, count and overrun next-state
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovr_d   = ovr_q;

        if (push_acc_s) begin
            wp_d = wp_q + PTR_INC;
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d = rp_q + PTR_INC;
        end else begin
            rp_d = rp_q;
        end

        case ({push_acc_s, pop_s})
            2'b10:   count_d = count_q + CNT_INC;
            2'b01:   count_d = count_q - CNT_INC;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (ICLR_OVR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge ISCLK or negedge IRST_N) begin
        if (!IRST_N) begin
            state_q <= S_IDLE;
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    // Byte storage; contents intentionally survive reset since count gates visibility
    always_ff @(posedge ISCLK) begin
        if (push_acc_s) begin
            mem_q[wp_q] <= IRXDATA;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        OVALID   = (count_q != CNT_ZERO);
        OFULL    = (count_q == CNT_FULL);
        OCOUNT   = count_q;
        OOVERRUN = ovr_q;
        if (count_q != CNT_ZERO) begin
            ODATA = mem_q[rp_q];
        end else begin
            ODATA = 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed, self-checking bench for uart_rx_fifo (DEPTH=8). Inputs are driven
// and outputs sampled on the falling clock edge, away from the active edge.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic        isclk;
    logic        irst_n;
    logic [7:0]  irxdata;
    logic        irx_busy;
    logic        ird;
    logic        iclr_ovr;
    logic [7:0]  odata;
    logic        ovalid;
    logic        ofull;
    logic [3:0]  ocount;
    logic        ooverrun;

    int checks_r;
    int errors_r;

    uart_rx_fifo #(
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .ISCLK    (isclk),
        .IRST_N   (irst_n),
        .IRXDATA  (irxdata),
        .IRX_BUSY (irx_busy),
        .IRD      (ird),
        .ICLR_OVR (iclr_ovr),
        .ODATA    (odata),
        .OVALID   (ovalid),
        .OFULL    (ofull),
        .OCOUNT   (ocount),
        .OOVERRUN (ooverrun)
    );

    // 10 ns clock
    initial begin
        isclk = 1'b0;
        forever #5 isclk = ~isclk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge isclk);
    endtask

    // One receiver frame: busy high for len cycles, then low. IRD / ICLR_OVR
    // can be raised in the push cycle (first edge that sees busy low).
    task automatic send_byte(input logic [7:0] b, input int len,
                             input logic rd_at_push, input logic clr_at_push);
        irxdata  = b;
        irx_busy = 1'b1;
        tick(len);
        irx_busy = 1'b0;
        ird      = rd_at_push;
        iclr_ovr = clr_at_push;
        tick(1);
        ird      = 1'b0;
        iclr_ovr = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        ird = 1'b1;
        tick(1);
        ird = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;
        checks_r = 0;
        errors_r = 0;
        irst_n   = 1'b0;
        irxdata  = 8'h00;
        irx_busy = 1'b0;
        ird      = 1'b0;
        iclr_ovr = 1'b0;

        // Reset state
        tick(2);
        check_val("rst_count", 32'(ocount), 32'd0);
        check_val("rst_valid", 32'(ovalid), 32'd0);
        check_val("rst_full",  32'(ofull),  32'd0);
        check_val("rst_data",  32'(odata),  32'h00);
        check_val("rst_ovr",   32'(ooverrun), 32'd0);

        // Reset released while busy is high: the partial frame still pushes
        irxdata  = 8'h9E;
        irx_busy = 1'b1;
        tick(1);
        irst_n = 1'b1;
        tick(3);
        irx_busy = 1'b0;
        tick(2);
        check_val("rel_busy_count", 32'(ocount), 32'd1);
        check_val("rel_busy_data",  32'(odata),  32'h9E);
        pop_one();
        check_val("rel_busy_empty", 32'(ocount), 32'd0);

        // Reset mid-fill, asserted between edges
        send_byte(8'h11, 3, 1'b0, 1'b0);
        send_byte(8'h22, 3, 1'b0, 1'b0);
        send_byte(8'h33, 3, 1'b0, 1'b0);
        check_val("midfill_count", 32'(ocount), 32'd3);
        #2;
        irst_n = 1'b0;
        #1;
        check_val("async_rst_count", 32'(ocount), 32'd0);
        check_val("async_rst_valid", 32'(ovalid), 32'd0);
        check_val("async_rst_data",  32'(odata),  32'h00);
        tick(1);
        irst_n = 1'b1;
        tick(1);

        // Single byte with a long frame
        send_byte(8'hA5, 150, 1'b0, 1'b0);
        check_val("single_valid", 32'(ovalid), 32'd1);
        check_val("single_data",  32'(odata),  32'hA5);
        check_val("single_count", 32'(ocount), 32'd1);
        pop_one();
        check_val("single_pop_valid", 32'(ovalid), 32'd0);
        check_val("single_pop_data",  32'(odata),  32'h00);

        // Pop on empty is ignored
        pop_one();
        check_val("empty_pop_count", 32'(ocount), 32'd0);

        // Fill to full
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 4, 1'b0, 1'b0);
        end
        check_val("fill_full",  32'(ofull),  32'd1);
        check_val("fill_count", 32'(ocount), 32'd8);
        check_val("fill_head",  32'(odata),  32'h01);

        // Overrun: dropped byte
        send_byte(8'hFF, 4, 1'b0, 1'b0);
        check_val("ovr_set",   32'(ooverrun), 32'd1);
        check_val("ovr_count", 32'(ocount),   32'd8);
        check_val("ovr_head",  32'(odata),    32'h01);

        // Clear together with a second drop: set wins
        send_byte(8'hEE, 4, 1'b0, 1'b1);
        check_val("ovr_clr_drop", 32'(ooverrun), 32'd1);
        check_val("ovr_clr_drop_count", 32'(ocount), 32'd8);

        // Clear alone
        iclr_ovr = 1'b1;
        tick(1);
        iclr_ovr = 1'b0;
        check_val("ovr_clr", 32'(ooverrun), 32'd0);

        // Full FIFO, push and pop in the same cycle: accepted, no overrun
        send_byte(8'h55, 4, 1'b1, 1'b0);
        check_val("full_pp_ovr",   32'(ooverrun), 32'd0);
        check_val("full_pp_count", 32'(ocount),   32'd8);
        check_val("full_pp_head",  32'(odata),    32'h02);

        // Drain: 02..08 then 55, then empty
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'(i + 2) : 8'h55;
            check_val($sformatf("drain_%0d", i), 32'(odata), 32'(exp_b));
            pop_one();
        end
        check_val("drain_valid", 32'(ovalid), 32'd0);
        check_val("drain_data",  32'(odata),  32'h00);

        // Empty FIFO, push with IRD: only the push takes effect
        send_byte(8'h3C, 4, 1'b1, 1'b0);
        check_val("empty_pp_count", 32'(ocount), 32'd1);
        check_val("empty_pp_data",  32'(odata),  32'h3C);
        pop_one();
        check_val("empty_pp_drain", 32'(ocount), 32'd0);

        // Wrap-around: 20 push/pop pairs
        for (int i = 0; i < 20; i++) begin
            exp_b = 8'h40 + 8'(i);
            send_byte(exp_b, 2, 1'b0, 1'b0);
            check_val($sformatf("wrap_data_%0d", i), 32'(odata), 32'(exp_b));
            pop_one();
            check_val($sformatf("wrap_cnt_%0d", i), 32'(ocount), 32'd0);
        end

        // 1-cycle busy pulse: exactly one push
        send_byte(8'hC3, 1, 1'b0, 1'b0);
        tick(4);
        check_val("pulse_count", 32'(ocount), 32'd1);
        check_val("pulse_data",  32'(odata),  32'hC3);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
